// File: rtl/os_pkg.sv
// Shared constants, FSM state type and flush-length helper for the systolic-array feeder.
package os_pkg;

    localparam int unsigned OS_N  = 4;
    localparam int unsigned OS_DW = 32;
    localparam int unsigned OS_KW = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } os_state_t;

    // Zero cycles needed after the last beat: N to leave the deepest lane, N-1 to cross the grid.
    function automatic int unsigned flush_len(input int unsigned n);
        return 2 * n - 1;
    endfunction

    localparam int unsigned OS_FLUSH_LEN = 2 * OS_N - 1;

endpackage

// File: rtl/os_feeder_if.sv
// Job/beat input bus of the feeder: start request, beat length and the valid/ready operand stream.
interface os_feeder_if #(
    parameter int unsigned N  = os_pkg::OS_N,
    parameter int unsigned DW = os_pkg::OS_DW,
    parameter int unsigned KW = os_pkg::OS_KW
);
    logic            start;
    logic [KW-1:0]   k_len;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_a;
    logic [N*DW-1:0] in_b;

    modport master (
        output start, k_len, in_valid, in_a, in_b,
        input  in_ready
    );

    modport slave (
        input  start, k_len, in_valid, in_a, in_b,
        output in_ready
    );

endinterface

// File: rtl/os_skew_line.sv
// Fixed-depth delay line for one array-edge lane; every stage shifts every cycle.
module os_skew_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/os_feeder.sv
// Input sequencer for the output-stationary systolic array: clears the grid, streams skewed
// A/B beats (zeros on bubbles), flushes with zeros and pulses done.
module os_feeder
    import os_pkg::*;
#(
    parameter int unsigned N  = OS_N,
    parameter int unsigned DW = OS_DW,
    parameter int unsigned KW = OS_KW
) (
    input  logic            clk,
    input  logic            rstn,
    os_feeder_if.slave      bus,
    output logic [N*DW-1:0] opA,
    output logic [N*DW-1:0] opB,
    output logic            rstnPipe,
    output logic            rstnPsum,
    output logic            busy,
    output logic            done
);

    localparam int unsigned FLEN = flush_len(N);
    localparam int unsigned FCW  = $clog2(FLEN + 1);

    os_state_t       state;
    os_state_t       state_nxt;
    logic [KW-1:0]   klen_q;
    logic [KW-1:0]   cnt;
    logic [FCW-1:0]  fcnt;
    logic            accept;
    logic [N*DW-1:0] push_a;
    logic [N*DW-1:0] push_b;

    assign bus.in_ready = (state == ST_STREAM);
    assign accept       = bus.in_valid && (state == ST_STREAM);

    // Bubbles push zero on every lane at once so they stay aligned through the grid.
    assign push_a = accept ? bus.in_a : '0;
    assign push_b = accept ? bus.in_b : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.start && (bus.k_len != '0)) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (accept && ((cnt + KW'(1)) == klen_q)) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fcnt == FCW'(FLEN - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered control outputs (outputs follow the next state).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            klen_q   <= '0;
            cnt      <= '0;
            fcnt     <= '0;
            rstnPipe <= 1'b0;
            rstnPsum <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && (state_nxt == ST_CLEAR)) begin
                klen_q <= bus.k_len;
            end
            if (state == ST_CLEAR) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + KW'(1);
            end
            if (state == ST_FLUSH) begin
                fcnt <= fcnt + FCW'(1);
            end else begin
                fcnt <= '0;
            end
            rstnPipe <= (state_nxt != ST_CLEAR);
            rstnPsum <= (state_nxt != ST_CLEAR);
            busy     <= (state_nxt == ST_CLEAR) || (state_nxt == ST_STREAM) ||
                        (state_nxt == ST_FLUSH);
            done     <= (state_nxt == ST_DONE);
        end
    end

    // Lane i is delayed i+1 cycles on both edges of the array.
    for (genvar i = 0; i < int'(N); i++) begin : g_lane
        os_skew_line #(
            .DEPTH (i + 1),
            .DW    (DW)
        ) u_skew_a (
            .clk  (clk),
            .rstn (rstn),
            .d    (push_a[i*DW +: DW]),
            .q    (opA[i*DW +: DW])
        );

        os_skew_line #(
            .DEPTH (i + 1),
            .DW    (DW)
        ) u_skew_b (
            .clk  (clk),
            .rstn (rstn),
            .d    (push_b[i*DW +: DW]),
            .q    (opB[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_os_feeder.sv
// Directed self-checking bench for os_feeder, including a behavioural 4x4 output-stationary grid.
module tb_os_feeder;
    import os_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned KW = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    os_feeder_if #(.N(N), .DW(DW), .KW(KW)) bus ();

    logic [N*DW-1:0] opA;
    logic [N*DW-1:0] opB;
    logic            rstnPipe;
    logic            rstnPsum;
    logic            busy;
    logic            done;

    os_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .opA      (opA),
        .opB      (opB),
        .rstnPipe (rstnPipe),
        .rstnPsum (rstnPsum),
        .busy     (busy),
        .done     (done)
    );

    int errors = 0;
    int checks = 0;

    // Reference output-stationary PE grid fed by the feeder.
    logic [DW-1:0] pe_a [N][N];
    logic [DW-1:0] pe_b [N][N];
    logic [DW-1:0] psum [N][N];

    always @(posedge clk) begin : pe_grid
        logic [DW-1:0] pa;
        logic [DW-1:0] pb;
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                if (j == 0) pa = opA[i*DW +: DW];
                else        pa = pe_a[i][j-1];
                if (i == 0) pb = opB[j*DW +: DW];
                else        pb = pe_b[i-1][j];
                if (!rstnPipe) begin
                    pe_a[i][j] <= '0;
                    pe_b[i][j] <= '0;
                end else begin
                    pe_a[i][j] <= pa;
                    pe_b[i][j] <= pb;
                end
                if (!rstnPsum) psum[i][j] <= '0;
                else           psum[i][j] <= psum[i][j] + pa * pb;
            end
        end
    end

    function automatic logic [DW-1:0] lane(input logic [N*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.k_len    = '0;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        step();
        step();
        checks++;
        if (opA !== '0) begin
            errors++; $display("FAIL reset_opA: got %0h expected 0", opA);
        end
        checks++;
        if (opB !== '0) begin
            errors++; $display("FAIL reset_opB: got %0h expected 0", opB);
        end
        checks++;
        if ({rstnPipe, rstnPsum, busy, done, bus.in_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {rstnPipe, rstnPsum, busy, done, bus.in_ready});
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (rstnPipe !== 1'b0) begin
            errors++; $display("FAIL release_before_edge: got %b expected 0", rstnPipe);
        end
        step();
        checks++;
        if ({rstnPipe, rstnPsum, busy, bus.in_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL release_after_edge: got %b expected 1100",
                     {rstnPipe, rstnPsum, busy, bus.in_ready});
        end
    endtask

    task automatic test_single_beat();
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        bus.start    = 1'b1;
        bus.k_len    = 16'd1;
        bus.in_valid = 1'b1;
        bus.in_a     = {32'd4, 32'd3, 32'd2, 32'd1};
        bus.in_b     = {32'd8, 32'd7, 32'd6, 32'd5};
        for (int c = 0; c <= 11; c++) begin
            if (c == 1) bus.start = 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                ea = (c == 3 + i) ? 32'(i + 1) : 32'd0;
                eb = (c == 3 + i) ? 32'(i + 5) : 32'd0;
                checks++;
                if (lane(opA, i) !== ea) begin
                    errors++;
                    $display("FAIL single_opA c=%0d lane=%0d: got %0h expected %0h",
                             c, i, lane(opA, i), ea);
                end
                checks++;
                if (lane(opB, i) !== eb) begin
                    errors++;
                    $display("FAIL single_opB c=%0d lane=%0d: got %0h expected %0h",
                             c, i, lane(opB, i), eb);
                end
            end
            checks++;
            if (rstnPsum !== (c != 1)) begin
                errors++; $display("FAIL single_psum_clr c=%0d: got %b", c, rstnPsum);
            end
            checks++;
            if (done !== (c == 10)) begin
                errors++; $display("FAIL single_done c=%0d: got %b", c, done);
            end
            checks++;
            if (busy !== (c >= 1 && c <= 9)) begin
                errors++; $display("FAIL single_busy c=%0d: got %b", c, busy);
            end
            checks++;
            if (bus.in_ready !== (c == 2)) begin
                errors++; $display("FAIL single_ready c=%0d: got %b", c, bus.in_ready);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_stalls();
        int acc [3] = '{2, 5, 6};
        int kk;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        bus.start = 1'b1;
        bus.k_len = 16'd3;
        for (int c = 0; c <= 16; c++) begin
            if (c == 1) bus.start = 1'b0;
            kk = -1;
            for (int k = 0; k < 3; k++) if (acc[k] == c) kk = k;
            // Garbage data with valid outside STREAM and during stalls must never surface.
            bus.in_valid = (kk >= 0) || (c < 2) || (c > 6);
            for (int i = 0; i < int'(N); i++) begin
                bus.in_a[i*DW +: DW] = (kk >= 0) ? 32'(32'h100 * (kk + 1) + i + 1) : 32'hDEADBEEF;
                bus.in_b[i*DW +: DW] = (kk >= 0) ? 32'(32'h1000 * (kk + 1) + i + 1) : 32'hCAFEF00D;
            end
            for (int i = 0; i < int'(N); i++) begin
                ea = '0;
                eb = '0;
                for (int k = 0; k < 3; k++) begin
                    if (acc[k] + 1 + i == c) begin
                        ea = 32'(32'h100 * (k + 1) + i + 1);
                        eb = 32'(32'h1000 * (k + 1) + i + 1);
                    end
                end
                checks++;
                if (lane(opA, i) !== ea) begin
                    errors++;
                    $display("FAIL stall_opA c=%0d lane=%0d: got %0h expected %0h",
                             c, i, lane(opA, i), ea);
                end
                checks++;
                if (lane(opB, i) !== eb) begin
                    errors++;
                    $display("FAIL stall_opB c=%0d lane=%0d: got %0h expected %0h",
                             c, i, lane(opB, i), eb);
                end
            end
            checks++;
            if (done !== (c == 14)) begin
                errors++; $display("FAIL stall_done c=%0d: got %b", c, done);
            end
            checks++;
            if (busy !== (c >= 1 && c <= 13)) begin
                errors++; $display("FAIL stall_busy c=%0d: got %b", c, busy);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_ignored();
        int ndone;
        bus.start = 1'b1;
        bus.k_len = '0;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({busy, rstnPsum, bus.in_ready} !== 3'b010) begin
                errors++;
                $display("FAIL zero_klen c=%0d: got %b expected 010",
                         c, {busy, rstnPsum, bus.in_ready});
            end
            step();
        end
        ndone = 0;
        bus.start    = 1'b1;
        bus.k_len    = 16'd1;
        bus.in_valid = 1'b1;
        bus.in_a     = {32'd1, 32'd1, 32'd1, 32'd1};
        bus.in_b     = {32'd2, 32'd2, 32'd2, 32'd2};
        for (int c = 0; c <= 16; c++) begin
            if (c == 1) bus.start = 1'b0;
            if (c == 5) begin
                bus.start = 1'b1;
                bus.k_len = 16'd5;
            end
            if (c == 6) bus.start = 1'b0;
            if (done === 1'b1) ndone++;
            checks++;
            if (done !== (c == 10)) begin
                errors++; $display("FAIL flush_start_done c=%0d: got %b", c, done);
            end
            step();
        end
        checks++;
        if (ndone != 1) begin
            errors++; $display("FAIL flush_start_count: got %0d expected 1", ndone);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL flush_start_idle: got %b expected 0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        int ndone;
        bus.start    = 1'b1;
        bus.k_len    = 16'd4;
        bus.in_valid = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            bus.in_a[i*DW +: DW] = 32'(32'hA0 + i);
            bus.in_b[i*DW +: DW] = 32'(32'hB0 + i);
        end
        step();
        bus.start = 1'b0;
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_first_stream: got %b expected 1", bus.in_ready);
        end
        step();
        checks++;
        if (lane(opA, 0) !== 32'hA0) begin
            errors++; $display("FAIL mid_lane0_before: got %0h expected a0", lane(opA, 0));
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({opA, opB} !== '0) begin
            errors++; $display("FAIL mid_reset_ops: got %0h expected 0", {opA, opB});
        end
        checks++;
        if ({rstnPipe, rstnPsum, busy, done, bus.in_ready} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got %b expected 00000",
                     {rstnPipe, rstnPsum, busy, done, bus.in_ready});
        end
        idle_inputs();
        step();
        step();
        @(negedge clk);
        rstn = 1'b1;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++; $display("FAIL mid_reset_no_done: got %0d expected 0", ndone);
        end
        bus.start    = 1'b1;
        bus.k_len    = 16'd2;
        bus.in_valid = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (c == 1) bus.start = 1'b0;
            checks++;
            if (done !== (c == 11)) begin
                errors++; $display("FAIL post_reset_done c=%0d: got %b", c, done);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_end_to_end();
        int c;
        bus.start = 1'b1;
        bus.k_len = 16'd4;
        for (c = 0; c < 40; c++) begin
            if (c == 1) bus.start = 1'b0;
            if (c >= 2 && c <= 5) begin
                bus.in_valid = 1'b1;
                for (int i = 0; i < int'(N); i++) begin
                    bus.in_a[i*DW +: DW] = (i == c - 2) ? 32'd1 : 32'd0;
                    bus.in_b[i*DW +: DW] = 32'(4 * (c - 2) + i + 1);
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            if (done === 1'b1) break;
            step();
        end
        checks++;
        if (c != 13) begin
            errors++; $display("FAIL e2e_done_cycle: got %0d expected 13", c);
        end
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                checks++;
                if (psum[i][j] !== 32'(4 * i + j + 1)) begin
                    errors++;
                    $display("FAIL e2e_psum(%0d,%0d): got %0d expected %0d",
                             i, j, psum[i][j], 4 * i + j + 1);
                end
            end
        end
        idle_inputs();
        step();
        checks++;
        if ({opA, opB} !== '0) begin
            errors++; $display("FAIL e2e_idle_zero: got %0h expected 0", {opA, opB});
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_stalls();
        test_ignored();
        test_mid_reset();
        test_end_to_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
